alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 46 ++++
 rtl/alu_sequencer_if.sv | 50 +++++
 rtl/alu_sequencer_instr_decode.sv | 39 +++
 rtl/alu_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_sequencer_pkg : opcode, ALU-operation and FSM-state encodings
// Revision 1.0
// ----------------------------------------------------------------------------
package alu_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned RA_W   = 2;
  localparam int unsigned OFF_W  = 5;

  localparam logic [ADDR_W-1:0] PC_STEP = 8'd1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAND = 3'b010,
    OP_ADDI = 3'b011,
    OP_SUBI = 3'b100,
    OP_BZ   = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_NAND = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  function automatic logic [ADDR_W-1:0] sext_off(input logic [OFF_W-1:0] off);
    return {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_sequencer_if : instruction-fetch, register-file and ALU bus
// Revision 1.0
// ----------------------------------------------------------------------------
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [DATA_W-1:0] imem_data;

  logic [RA_W-1:0]   rf_raddr1;
  logic [RA_W-1:0]   rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [RA_W-1:0]   alu_imm2;
  logic              alu_imm_sel;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_data,
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    output rf_we, rf_waddr, rf_wdata,
    output alu_src1, alu_src2, alu_imm2, alu_imm_sel, alu_op,
    input  alu_result, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_data,
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    input  rf_we, rf_waddr, rf_wdata,
    input  alu_src1, alu_src2, alu_imm2, alu_imm_sel, alu_op,
    output alu_result, alu_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer_instr_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_decode : opcode to ALU control and instruction-class flags
// Revision 1.0
// ----------------------------------------------------------------------------
module instr_decode
  import alu_sequencer_pkg::*;
(
  input  logic [2:0] opcode,
  output alu_op_e    alu_op,
  output logic       imm_sel,
  output logic       is_alu,
  output logic       is_bz,
  output logic       is_halt,
  output logic       is_nop
);

  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = 1'b0;
    is_alu  = 1'b0;
    is_bz   = 1'b0;
    is_halt = 1'b0;
    is_nop  = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD:  is_alu = 1'b1;
      OP_SUB:  begin alu_op = ALU_SUB;  is_alu = 1'b1; end
      OP_NAND: begin alu_op = ALU_NAND; is_alu = 1'b1; end
      OP_ADDI: begin imm_sel = 1'b1;    is_alu = 1'b1; end
      OP_SUBI: begin alu_op = ALU_SUB;  imm_sel = 1'b1; is_alu = 1'b1; end
      OP_BZ:   is_bz   = 1'b1;
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_sequencer : multi-cycle fetch / decode / execute / writeback sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  alu_sequencer_if.master   bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              zflag
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rzero_q, rzero_d;
  logic              zflag_q, zflag_d;

  alu_op_e           dec_alu_op;
  logic              dec_imm_sel, is_alu, is_bz, is_halt, is_nop;
  logic [RA_W-1:0]   rd, field;
  logic [OFF_W-1:0]  off;

  assign rd    = instr_q[4:3];
  assign field = instr_q[2:1];
  assign off   = instr_q[4:0];

  instr_decode u_decode (
    .opcode  (instr_q[7:5]),
    .alu_op  (dec_alu_op),
    .imm_sel (dec_imm_sel),
    .is_alu  (is_alu),
    .is_bz   (is_bz),
    .is_halt (is_halt),
    .is_nop  (is_nop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= PC_RESET;
      instr_q  <= '0;
      result_q <= '0;
      rzero_q  <= 1'b0;
      zflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      rzero_q  <= rzero_d;
      zflag_q  <= zflag_d;
    end
  end

  // Strobes decode straight from state_q so an asynchronous reset drops them at once.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    result_d        = result_q;
    rzero_d         = rzero_q;
    zflag_d         = zflag_q;
    bus.imem_req    = 1'b0;
    bus.imem_addr   = pc_q;
    bus.rf_raddr1   = rd;
    bus.rf_raddr2   = field;
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = rd;
    bus.rf_wdata    = result_q;
    bus.alu_src1    = '0;
    bus.alu_src2    = '0;
    bus.alu_imm2    = '0;
    bus.alu_imm_sel = 1'b0;
    bus.alu_op      = ALU_ADD;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = PC_RESET;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_valid) begin
          instr_d = bus.imem_data;
          pc_d    = pc_q + PC_STEP;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu) begin
          state_d = ST_EXECUTE;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else if (is_bz || is_nop) begin
          state_d = ST_FETCH;
          // Branch offset is relative to the already-incremented pc.
          if (is_bz && zflag_q) pc_d = pc_q + sext_off(off);
        end
      end
      ST_EXECUTE: begin
        bus.alu_src1    = bus.rf_rdata1;
        bus.alu_src2    = bus.rf_rdata2;
        bus.alu_imm2    = field;
        bus.alu_imm_sel = dec_imm_sel;
        bus.alu_op      = dec_alu_op;
        result_d        = bus.alu_result;
        rzero_d         = bus.alu_zero;
        state_d         = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        bus.rf_we = 1'b1;
        zflag_d   = rzero_q;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALT);
  assign zflag  = zflag_q;

endmodule
`default_nettype wire
